// File: rtl/trap_ctrl.sv
// Trap controller: prioritises fetch misalignment and external exception sources,
// latches mepc/mcause/mtval, redirects to a direct or vectored handler and returns on MRET.
module trap_ctrl #(
  parameter int              XLEN      = 32,
  parameter int              NUM_SRC   = 4,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(32'h0000_0004),
  parameter int              MRET_SKIP = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    instr_valid,
  input  logic [XLEN-1:0]         pc_in,
  input  logic [XLEN-1:0]         instr_addr,
  input  logic [NUM_SRC-1:0]      exc_req,
  input  logic [NUM_SRC*4-1:0]    exc_cause_in,
  input  logic [NUM_SRC*XLEN-1:0] exc_tval_in,
  input  logic                    mret,
  input  logic                    mtvec_we,
  input  logic [XLEN-1:0]         mtvec_wdata,
  output logic                    redirect_valid,
  output logic [XLEN-1:0]         redirect_pc,
  output logic                    flush,
  output logic                    trap_taken,
  output logic                    in_handler,
  output logic                    halted,
  output logic [XLEN-1:0]         mepc,
  output logic [XLEN-1:0]         mcause,
  output logic [XLEN-1:0]         mtval,
  output logic [XLEN-1:0]         mtvec
);

  typedef enum logic [2:0] {IDLE, TRAP, HANDLER, RETURN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [XLEN-1:0] mepc_q, mepc_d;
  logic [XLEN-1:0] mcause_q, mcause_d;
  logic [XLEN-1:0] mtval_q, mtval_d;
  logic [XLEN-1:0] mtvec_q, mtvec_d;

  logic            misaligned;
  logic            exc_any;
  logic [3:0]      sel_cause;
  logic [XLEN-1:0] sel_tval;
  logic [XLEN-1:0] cause_x;
  logic [XLEN-1:0] base;
  logic [XLEN-1:0] handler_pc;
  logic [XLEN-1:0] ret_pc;

  assign misaligned = (instr_addr[1:0] != 2'b00);
  assign exc_any    = instr_valid & (misaligned | (|exc_req));

  // Scan from the top index down so the lowest set source ends up selected.
  always_comb begin
    sel_cause = 4'd0;
    sel_tval  = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (exc_req[i]) begin
        sel_cause = exc_cause_in[4*i +: 4];
        sel_tval  = exc_tval_in[XLEN*i +: XLEN];
      end
    end
    if (misaligned) begin
      sel_cause = 4'd0;
      sel_tval  = instr_addr;
    end
  end

  assign cause_x    = XLEN'(sel_cause);
  assign base       = {mtvec_q[XLEN-1:2], 2'b00};
  assign handler_pc = (mtvec_q[1:0] == 2'b01) ? (base + (cause_x << 2)) : base;
  assign ret_pc     = mepc_q + ((MRET_SKIP != 0) ? XLEN'(4) : XLEN'(0));

  always_comb begin
    state_d       = state_q;
    redirect_pc_d = redirect_pc_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mtvec_d       = mtvec_q;
    // mtvec is frozen once halted; a same-edge trap already used the old value.
    if (mtvec_we && state_q != HALT) mtvec_d = mtvec_wdata;
    unique case (state_q)
      IDLE: begin
        if (exc_any) begin
          state_d       = TRAP;
          mepc_d        = pc_in;
          mcause_d      = cause_x;
          mtval_d       = sel_tval;
          redirect_pc_d = handler_pc;
        end
      end
      TRAP:    state_d = HANDLER;
      HANDLER: begin
        if (exc_any) begin
          state_d = HALT;
        end else if (instr_valid && mret) begin
          state_d       = RETURN;
          redirect_pc_d = ret_pc;
        end
      end
      RETURN:  state_d = IDLE;
      HALT:    state_d = HALT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = 1'b0;
    flush          = 1'b0;
    trap_taken     = 1'b0;
    in_handler     = 1'b0;
    halted         = 1'b0;
    unique case (state_q)
      TRAP: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        trap_taken     = 1'b1;
      end
      HANDLER: in_handler = 1'b1;
      RETURN: begin
        redirect_valid = 1'b1;
        flush          = 1'b1;
        in_handler     = 1'b1;
      end
      HALT: begin
        halted = 1'b1;
        flush  = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      redirect_pc_q <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mtvec_q       <= RESET_VEC;
    end else begin
      state_q       <= state_d;
      redirect_pc_q <= redirect_pc_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mtvec_q       <= mtvec_d;
    end
  end

  assign redirect_pc = redirect_pc_q;
  assign mepc        = mepc_q;
  assign mcause      = mcause_q;
  assign mtval       = mtval_q;
  assign mtvec       = mtvec_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed testbench for trap_ctrl: trap entry, priority, vectoring, MRET, double fault, reset.
module tb_trap_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic         instr_valid;
  logic [31:0]  pc_in;
  logic [31:0]  instr_addr;
  logic [3:0]   exc_req;
  logic [15:0]  exc_cause_in;
  logic [127:0] exc_tval_in;
  logic         mret;
  logic         mtvec_we;
  logic [31:0]  mtvec_wdata;
  logic         redirect_valid;
  logic [31:0]  redirect_pc;
  logic         flush;
  logic         trap_taken;
  logic         in_handler;
  logic         halted;
  logic [31:0]  mepc;
  logic [31:0]  mcause;
  logic [31:0]  mtval;
  logic [31:0]  mtvec;

  int checks   = 0;
  int failures = 0;

  trap_ctrl dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .pc_in(pc_in),
    .instr_addr(instr_addr), .exc_req(exc_req), .exc_cause_in(exc_cause_in),
    .exc_tval_in(exc_tval_in), .mret(mret), .mtvec_we(mtvec_we),
    .mtvec_wdata(mtvec_wdata), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush), .trap_taken(trap_taken),
    .in_handler(in_handler), .halted(halted), .mepc(mepc), .mcause(mcause),
    .mtval(mtval), .mtvec(mtvec)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    instr_valid  = 1'b0;
    pc_in        = 32'h0;
    instr_addr   = 32'h0;
    exc_req      = 4'b0;
    exc_cause_in = 16'h0;
    exc_tval_in  = 128'h0;
    mret         = 1'b0;
    mtvec_we     = 1'b0;
    mtvec_wdata  = 32'h0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Presents a misaligned fetch for one cycle; afterwards the DUT is in TRAP.
  task automatic misaligned_trap(input logic [31:0] pc, input logic [31:0] addr);
    instr_valid = 1'b1; pc_in = pc; instr_addr = addr;
    tick();
    clear_inputs();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if ({redirect_valid, flush, trap_taken, in_handler, halted} !== 5'b0) begin
      failures++; $display("FAIL reset_flags got=%b exp=00000", {redirect_valid, flush, trap_taken, in_handler, halted}); end
    checks++; if ({redirect_pc, mepc, mcause, mtval} !== 128'h0) begin
      failures++; $display("FAIL reset_csrs got=%h exp=0", {redirect_pc, mepc, mcause, mtval}); end
    checks++; if (mtvec !== 32'h4) begin
      failures++; $display("FAIL reset_mtvec got=%h exp=00000004", mtvec); end
    $display("reset: mtvec=%h", mtvec);
  endtask

  task automatic test_misaligned();
    do_reset();
    misaligned_trap(32'h100, 32'h102);
    checks++; if ({redirect_valid, flush, trap_taken, in_handler} !== 4'b1110) begin
      failures++; $display("FAIL mis_trap_flags got=%b exp=1110", {redirect_valid, flush, trap_taken, in_handler}); end
    checks++; if (redirect_pc !== 32'h4) begin
      failures++; $display("FAIL mis_redirect_pc got=%h exp=00000004", redirect_pc); end
    checks++; if ({mepc, mcause, mtval} !== {32'h100, 32'h0, 32'h102}) begin
      failures++; $display("FAIL mis_csrs got=%h/%h/%h exp=100/0/102", mepc, mcause, mtval); end
    tick();
    checks++; if ({redirect_valid, flush, trap_taken, in_handler} !== 4'b0001) begin
      failures++; $display("FAIL mis_handler_flags got=%b exp=0001", {redirect_valid, flush, trap_taken, in_handler}); end
    $display("misaligned: mepc=%h mcause=%h mtval=%h", mepc, mcause, mtval);
  endtask

  task automatic test_priority();
    do_reset();
    instr_valid = 1'b1; pc_in = 32'h300; instr_addr = 32'h200;
    exc_req = 4'b0110; exc_cause_in = 16'h0520;
    exc_tval_in = {32'h0, 32'hBBBB2222, 32'hAAAA1111, 32'h0};
    tick();
    clear_inputs();
    checks++; if ({mepc, mcause, mtval} !== {32'h300, 32'h2, 32'hAAAA1111}) begin
      failures++; $display("FAIL prio_ext got=%h/%h/%h exp=300/2/aaaa1111", mepc, mcause, mtval); end
    do_reset();
    instr_valid = 1'b1; pc_in = 32'h300; instr_addr = 32'h203;
    exc_req = 4'b0110; exc_cause_in = 16'h0520;
    exc_tval_in = {32'h0, 32'hBBBB2222, 32'hAAAA1111, 32'h0};
    tick();
    clear_inputs();
    checks++; if ({mcause, mtval} !== {32'h0, 32'h203}) begin
      failures++; $display("FAIL prio_mis got=%h/%h exp=0/203", mcause, mtval); end
    $display("priority: mcause=%h mtval=%h", mcause, mtval);
  endtask

  task automatic test_vectored();
    do_reset();
    mtvec_we = 1'b1; mtvec_wdata = 32'h1001;
    tick();
    mtvec_we = 1'b0;
    checks++; if (mtvec !== 32'h1001) begin
      failures++; $display("FAIL vec_mtvec got=%h exp=00001001", mtvec); end
    instr_valid = 1'b1; pc_in = 32'h400; exc_req = 4'b0001; exc_cause_in = 16'h0003;
    tick();
    clear_inputs();
    checks++; if (redirect_pc !== 32'h100C) begin
      failures++; $display("FAIL vec_redirect_pc got=%h exp=0000100c", redirect_pc); end
    do_reset();
    mtvec_we = 1'b1; mtvec_wdata = 32'h1001;
    instr_valid = 1'b1; pc_in = 32'h400; exc_req = 4'b0001; exc_cause_in = 16'h0003;
    tick();
    clear_inputs();
    checks++; if (redirect_pc !== 32'h4) begin
      failures++; $display("FAIL vec_same_edge_pc got=%h exp=00000004", redirect_pc); end
    checks++; if (mtvec !== 32'h1001) begin
      failures++; $display("FAIL vec_same_edge_mtvec got=%h exp=00001001", mtvec); end
    $display("vectored: redirect_pc=%h mtvec=%h", redirect_pc, mtvec);
  endtask

  task automatic test_return();
    do_reset();
    instr_valid = 1'b1; mret = 1'b1; instr_addr = 32'h0;
    tick();
    clear_inputs();
    checks++; if ({redirect_valid, in_handler} !== 2'b00) begin
      failures++; $display("FAIL idle_mret got=%b exp=00", {redirect_valid, in_handler}); end
    misaligned_trap(32'h100, 32'h102);
    tick();
    instr_valid = 1'b1; mret = 1'b1;
    tick();
    clear_inputs();
    checks++; if ({redirect_valid, flush, trap_taken, in_handler} !== 4'b1101) begin
      failures++; $display("FAIL ret_flags got=%b exp=1101", {redirect_valid, flush, trap_taken, in_handler}); end
    checks++; if (redirect_pc !== 32'h104) begin
      failures++; $display("FAIL ret_pc got=%h exp=00000104", redirect_pc); end
    tick();
    checks++; if ({redirect_valid, flush, in_handler} !== 3'b000) begin
      failures++; $display("FAIL ret_idle got=%b exp=000", {redirect_valid, flush, in_handler}); end
    do_reset();
    misaligned_trap(32'hFFFFFFFC, 32'h2);
    tick();
    instr_valid = 1'b1; mret = 1'b1;
    tick();
    clear_inputs();
    checks++; if ({redirect_valid, redirect_pc} !== {1'b1, 32'h0}) begin
      failures++; $display("FAIL ret_wrap got=%b/%h exp=1/00000000", redirect_valid, redirect_pc); end
    $display("return: redirect_pc=%h", redirect_pc);
  endtask

  task automatic test_halt();
    do_reset();
    misaligned_trap(32'h100, 32'h102);
    tick();
    instr_valid = 1'b1; exc_req = 4'b0001; exc_cause_in = 16'h0007; mret = 1'b1;
    tick();
    clear_inputs();
    checks++; if ({halted, flush, redirect_valid, in_handler} !== 4'b1100) begin
      failures++; $display("FAIL halt_flags got=%b exp=1100", {halted, flush, redirect_valid, in_handler}); end
    checks++; if ({mepc, mcause, mtval} !== {32'h100, 32'h0, 32'h102}) begin
      failures++; $display("FAIL halt_csrs got=%h/%h/%h exp=100/0/102", mepc, mcause, mtval); end
    instr_valid = 1'b1; instr_addr = 32'h1; mtvec_we = 1'b1; mtvec_wdata = 32'h2000;
    tick();
    clear_inputs();
    checks++; if ({halted, redirect_valid, trap_taken} !== 3'b100) begin
      failures++; $display("FAIL halt_sticky got=%b exp=100", {halted, redirect_valid, trap_taken}); end
    checks++; if (mtvec !== 32'h4) begin
      failures++; $display("FAIL halt_mtvec got=%h exp=00000004", mtvec); end
    do_reset();
    checks++; if ({halted, flush, redirect_valid} !== 3'b000 || {mepc, mcause, mtval} !== 96'h0) begin
      failures++; $display("FAIL halt_reset got=%b %h exp=000 0", {halted, flush, redirect_valid}, {mepc, mcause, mtval}); end
    $display("halt: halted=%b mepc=%h", halted, mepc);
  endtask

  task automatic test_rst_in_trap();
    do_reset();
    misaligned_trap(32'h100, 32'h102);
    checks++; if (trap_taken !== 1'b1) begin
      failures++; $display("FAIL rst_trap_pre got=%b exp=1", trap_taken); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({redirect_valid, flush, trap_taken, in_handler, halted} !== 5'b0 || {redirect_pc, mepc, mcause, mtval} !== 128'h0) begin
      failures++; $display("FAIL rst_trap_clear got=%b %h exp=0 0", {redirect_valid, flush, trap_taken, in_handler, halted}, {redirect_pc, mepc, mcause, mtval}); end
    tick();
    checks++; if (in_handler !== 1'b0) begin
      failures++; $display("FAIL rst_trap_idle got=%b exp=0", in_handler); end
    $display("rst_in_trap: in_handler=%b", in_handler);
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_misaligned();
    test_priority();
    test_vectored();
    test_return();
    test_halt();
    test_rst_in_trap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
